gcd_lcm_stage: RTL and testbench

Downstream consumer of the `GCD` block. It takes an operand pair (A, B) together with their greatest common divisor G and computes the least common multiple, L = (A / G) × B. It uses a sequential restoring divider followed by a sequential shift-add multiplier. The block sits after the GCD cascade in `gcd_top`-style datapaths and presents the 2·W-bit result through a valid/ready handshake.

---
 rtl/gcd_lcm_stage_if.sv | 25 ++
 rtl/gcd_lcm_stage.sv | 137 +++++++++++++
 tb/tb_gcd_lcm_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gcd_lcm_stage_if.sv
// Operand/result handshake bundle between the GCD stage and the LCM stage.
// Upstream side is master, the LCM stage is slave.
interface gcd_lcm_stage_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [W-1:0]   G;
  logic [2*W-1:0] L;
  logic           err;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_valid, A, B, G, out_ready,
    input  in_ready, L, err, out_valid
  );

  modport slave (
    input  in_valid, A, B, G, out_ready,
    output in_ready, L, err, out_valid
  );
endinterface

// File: rtl/gcd_lcm_stage.sv
// LCM from (A, B, gcd G) via restoring divide then shift-add multiply; 2W cycles (1 for zero operands).
// Result held in DONE until out_ready; in_ready only in IDLE.
module gcd_lcm_stage #(
  parameter int W = 16
) (
  input logic            clk,
  input logic            reset,
  gcd_lcm_stage_if.slave io
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [W-1:0]   a_sh;
  logic [W-1:0]   g_q;
  logic [W-1:0]   q;
  logic [W-1:0]   rem;
  logic [2*W-1:0] b_sh;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] l_q;
  logic           err_q;
  logic           out_valid_q;

  logic [W:0]     rem_shift;
  logic [W:0]     rem_diff;
  logic           rem_ge;
  logic [W-1:0]   rem_next;
  logic [2*W-1:0] acc_next;
  logic           last_step;
  logic           accept;
  logic           zero_in;

  assign io.in_ready  = (state == IDLE);
  assign io.L         = l_q;
  assign io.err       = err_q;
  assign io.out_valid = out_valid_q;

  // Shifted remainder kept one bit wider so divisors above 2^(W-1) still compare correctly.
  always_comb begin
    rem_shift = {rem, a_sh[W-1]};
    rem_diff  = rem_shift - {1'b0, g_q};
    rem_ge    = (rem_shift >= {1'b0, g_q});
    rem_next  = rem_ge ? rem_diff[W-1:0] : rem_shift[W-1:0];
    acc_next  = q[0] ? (acc + b_sh) : acc;
    last_step = (cnt == CW'(W - 1));
    accept    = io.in_valid && (state == IDLE);
    zero_in   = (io.A == '0) || (io.B == '0) || (io.G == '0);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = zero_in ? DONE : DIV;
      DIV:  if (last_step) state_next = MUL;
      MUL:  if (last_step) state_next = DONE;
      DONE: if (io.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh        <= '0;
      g_q         <= '0;
      q           <= '0;
      rem         <= '0;
      b_sh        <= '0;
      acc         <= '0;
      cnt         <= '0;
      l_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh <= io.A;
            b_sh <= {{W{1'b0}}, io.B};
            g_q  <= io.G;
            q    <= '0;
            rem  <= '0;
            acc  <= '0;
            cnt  <= '0;
            if (zero_in) begin
              l_q         <= '0;
              err_q       <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DIV: begin
          rem  <= rem_next;
          q    <= {q[W-2:0], rem_ge};
          a_sh <= {a_sh[W-2:0], 1'b0};
          if (last_step) begin
            cnt   <= '0;
            err_q <= (rem_next != '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL: begin
          acc  <= acc_next;
          b_sh <= {b_sh[2*W-2:0], 1'b0};
          q    <= {1'b0, q[W-1:1]};
          if (last_step) begin
            cnt         <= '0;
            l_q         <= acc_next;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_lcm_stage.sv
// Directed plus random checks of gcd_lcm_stage against an arithmetic LCM model.
module tb_gcd_lcm_stage;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  gcd_lcm_stage_if #(.W(W)) io ();
  gcd_lcm_stage #(.W(W)) dut (.clk(clk), .reset(reset), .io(io));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] g, output logic [31:0] l,
                                output logic e);
    int unsigned ua, ub, ug;
    ua = a; ub = b; ug = g;
    if (ua == 0 || ub == 0 || ug == 0) begin
      l = 32'd0;
      e = 1'b0;
    end else begin
      l = 32'((ua / ug) * ub);
      e = (ua % ug) != 0;
    end
  endfunction

  function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
    int unsigned x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 16'(x);
  endfunction

  // Feed one operand set, check latency and result, optionally stall the consumer.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] g, input int stall);
    logic [31:0] exp_l;
    logic        exp_e;
    int          n;
    int          exp_lat;
    model(a, b, g, exp_l, exp_e);
    exp_lat = (a == 0 || b == 0 || g == 0) ? 1 : 2 * W;
    @(negedge clk);
    io.out_ready = (stall == 0);
    io.in_valid  = 1'b1;
    io.A = a; io.B = b; io.G = g;
    n = 0;
    while (!io.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 64'(io.in_ready), 64'd1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.A = 16'($urandom); io.B = 16'($urandom); io.G = 16'($urandom);
    n = 1;
    while (!io.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      if (!io.out_valid) n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_L"}, 64'(io.L), 64'(exp_l));
    check({tag, "_err"}, 64'(io.err), 64'(exp_e));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_stallL"}, 64'(io.L), 64'(exp_l));
      check({tag, "_stallrdy"}, 64'({io.in_ready, io.out_valid}), 64'b01);
    end
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_drain"}, 64'({io.in_ready, io.out_valid}), 64'b10);
  endtask

  initial begin
    logic [15:0] ra, rb, rg;
    int          hits;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    io.A = '0; io.B = '0; io.G = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_state", 64'({io.in_ready, io.out_valid, io.err, io.L}), 64'({3'b100, 32'd0}));

    do_op("basic", 16'd12, 16'd18, 16'd6, 0);
    do_op("max", 16'hFFFF, 16'hFFFE, 16'd1, 0);
    do_op("zero_a", 16'd0, 16'd25, 16'd25, 0);
    do_op("zero_all", 16'd0, 16'd0, 16'd0, 0);
    do_op("bad_g", 16'd10, 16'd4, 16'd3, 0);
    do_op("big_g", 16'hFFF0, 16'd3, 16'hFFF0, 0);
    do_op("stall", 16'd7, 16'd5, 16'd1, 10);
    do_op("after_stall", 16'd8, 16'd12, 16'd4, 0);

    // Abort an operation ten cycles into the divide.
    @(negedge clk);
    io.in_valid = 1'b1;
    io.A = 16'd200; io.B = 16'd3; io.G = 16'd8;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset", 64'({io.in_ready, io.out_valid, io.err, io.L}), 64'({3'b100, 32'd0}));
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (io.out_valid) hits++;
    end
    check("no_stale", 64'(hits), 64'd0);
    do_op("post_reset", 16'd21, 16'd6, 16'd3, 0);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) rg = 16'($urandom_range(1, 40));
      else rg = gcd16(ra, rb);
      if (i % 8 == 5) ra = 16'd0;
      do_op("rand", ra, rb, rg, (i % 4 == 1) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
